// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch flush, and the
// start/done handshake with the multi-cycle multiply/divide unit.
module hazard_ctrl #(
  parameter int unsigned MDU_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      RI_ID,
  input  logic [31:0]      RI_EX,
  input  logic [4:0]       rsW_EX,
  input  logic             branch_taken_EX,
  input  logic             mdu_done,
  output logic             PCWrite,
  output logic             IFID_Write,
  output logic             IF_Flush,
  output logic             IF_FlushH,
  output logic             idex_hold,
  output logic             mdu_start,
  output logic             mdu_error,
  output logic [CNT_W-1:0] stall_count
);

  localparam int unsigned TW = $clog2(MDU_TIMEOUT + 1);
  localparam logic [TW-1:0] TIMEOUT_V = TW'(MDU_TIMEOUT);

  typedef enum logic {RUN, MDU_WAIT} state_t;

  state_t           state_q, state_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;
  logic             mdu_error_q, mdu_error_d;

  logic       load_ex, mop_ex, rs1_used, rs2_used, lu_hazard;
  logic [6:0] op_id;
  logic       unused_ok;

  assign unused_ok = ^{RI_EX[24:7], RI_ID[31:25], RI_ID[14:7]};

  always_comb begin
    op_id     = RI_ID[6:0];
    load_ex   = (RI_EX[6:0] == 7'b0000011);
    mop_ex    = (RI_EX[6:0] == 7'b0110011) && (RI_EX[31:25] == 7'b0000001);
    rs1_used  = !(op_id == 7'b0110111 || op_id == 7'b0010111 || op_id == 7'b1101111);
    rs2_used  = (op_id == 7'b0110011 || op_id == 7'b0100011 || op_id == 7'b1100011);
    lu_hazard = load_ex && (rsW_EX != 5'd0) &&
                ((rs1_used && RI_ID[19:15] == rsW_EX) ||
                 (rs2_used && RI_ID[24:20] == rsW_EX));
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mdu_error_d = mdu_error_q;
    PCWrite     = 1'b1;
    IFID_Write  = 1'b1;
    IF_Flush    = 1'b0;
    IF_FlushH   = 1'b0;
    idex_hold   = 1'b0;
    mdu_start   = 1'b0;

    unique case (state_q)
      RUN: begin
        if (branch_taken_EX) begin
          IF_Flush  = 1'b1;
          IF_FlushH = 1'b1;
        end else if (mop_ex) begin
          mdu_start  = 1'b1;
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          idex_hold  = 1'b1;
          state_d    = MDU_WAIT;
          timer_d    = TW'(1);
        end else if (lu_hazard) begin
          PCWrite    = 1'b0;
          IFID_Write = 1'b0;
          IF_FlushH  = 1'b1;
        end
      end
      MDU_WAIT: begin
        PCWrite    = 1'b0;
        IFID_Write = 1'b0;
        idex_hold  = 1'b1;
        // done takes priority over a coincident timeout, so no error is flagged
        if (mdu_done || timer_q == TIMEOUT_V) begin
          PCWrite    = 1'b1;
          IFID_Write = 1'b1;
          idex_hold  = 1'b0;
          state_d    = RUN;
          if (!mdu_done) mdu_error_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = RUN;
    endcase

    if (reset) begin
      PCWrite    = 1'b1;
      IFID_Write = 1'b1;
      IF_Flush   = 1'b0;
      IF_FlushH  = 1'b0;
      idex_hold  = 1'b0;
      mdu_start  = 1'b0;
    end

    stall_count_d = stall_count_q;
    if (!PCWrite && stall_count_q != '1) stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      timer_q       <= '0;
      stall_count_q <= '0;
      mdu_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      stall_count_q <= stall_count_d;
      mdu_error_q   <= mdu_error_d;
    end
  end

  assign mdu_error   = mdu_error_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: decode table plus MDU/reset/saturation sequences.
module tb_hazard_ctrl;

  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [31:0]      RI_ID, RI_EX;
  logic [4:0]       rsW_EX;
  logic             branch_taken_EX, mdu_done;
  logic             PCWrite, IFID_Write, IF_Flush, IF_FlushH, idex_hold, mdu_start, mdu_error;
  logic [CNT_W-1:0] stall_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] LW_X5   = 32'h00002283;
  localparam logic [31:0] ADD_X5  = 32'h00728333; // add x6,x5,x7
  localparam logic [31:0] MUL     = 32'h02A585B3;
  localparam logic [5:0]  NORM    = 6'b110000;
  localparam logic [5:0]  LUSTALL = 6'b000100;
  localparam logic [5:0]  MSTART  = 6'b000011;
  localparam logic [5:0]  MWAIT   = 6'b000010;

  hazard_ctrl #(.MDU_TIMEOUT(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .RI_ID(RI_ID), .RI_EX(RI_EX), .rsW_EX(rsW_EX),
    .branch_taken_EX(branch_taken_EX), .mdu_done(mdu_done),
    .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IF_Flush(IF_Flush),
    .IF_FlushH(IF_FlushH), .idex_hold(idex_hold), .mdu_start(mdu_start),
    .mdu_error(mdu_error), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ri_id;
    logic [31:0] ri_ex;
    logic [4:0]  rsw;
    logic        br;
    logic [5:0]  exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [5:0] outs();
    return {PCWrite, IFID_Write, IF_Flush, IF_FlushH, idex_hold, mdu_start};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] id, input logic [31:0] ex, input logic [4:0] rsw,
                       input logic br, input logic done);
    RI_ID = id; RI_EX = ex; rsW_EX = rsw; branch_taken_EX = br; mdu_done = done;
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(ADD_X5, LW_X5, 5'd5, 1'b0, 1'b0);
    check("reset_outs", 32'(outs()), 32'(NORM));
    step();
    step();
    reset = 1'b0;
    check("reset_cnt", 32'(stall_count), 0);
    check("reset_err", 32'(mdu_error), 0);
  endtask

  initial begin
    int exp_stalls;

    vecs[0]  = '{32'h00000000, 32'h00000000, 5'd0, 1'b0, NORM};
    vecs[1]  = '{ADD_X5,       LW_X5,        5'd5, 1'b0, LUSTALL};
    vecs[2]  = '{32'h00700333, 32'h00002003, 5'd0, 1'b0, NORM};     // x0 destination
    vecs[3]  = '{32'h00040437, 32'h00002403, 5'd8, 1'b0, NORM};     // lui, rs1 field=8
    vecs[4]  = '{32'h0050A023, LW_X5,        5'd5, 1'b0, LUSTALL};  // sw rs2=x5
    vecs[5]  = '{32'h00508313, LW_X5,        5'd5, 1'b0, NORM};     // addi, rs2 field unused
    vecs[6]  = '{32'h000280EF, LW_X5,        5'd5, 1'b0, NORM};     // jal, rs1 field unused
    vecs[7]  = '{32'h00508063, LW_X5,        5'd5, 1'b0, LUSTALL};  // beq rs2=x5
    vecs[8]  = '{ADD_X5,       LW_X5,        5'd5, 1'b1, 6'b111100};
    vecs[9]  = '{ADD_X5,       ADD_X5,       5'd5, 1'b0, NORM};     // non-load in EX
    vecs[10] = '{32'h00208333, LW_X5,        5'd5, 1'b0, NORM};     // no register match
    vecs[11] = '{32'h00028317, LW_X5,        5'd5, 1'b0, NORM};     // auipc, rs1 field unused

    do_reset();

    exp_stalls = 0;
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].ri_id, vecs[i].ri_ex, vecs[i].rsw, vecs[i].br, 1'b0);
      check($sformatf("vec%0d", i), 32'(outs()), 32'(vecs[i].exp));
      if (!vecs[i].exp[5]) exp_stalls++;
      step();
    end
    check("table_cnt", 32'(stall_count), 32'(exp_stalls));

    // Single load-use bubble, then normal flow; stray mdu_done in RUN ignored
    do_reset();
    drive(ADD_X5, LW_X5, 5'd5, 1'b0, 1'b0);
    check("lu_stall", 32'(outs()), 32'(LUSTALL));
    step();
    drive(ADD_X5, 32'h0, 5'd0, 1'b0, 1'b1);
    check("lu_after", 32'(outs()), 32'(NORM));
    check("lu_cnt", 32'(stall_count), 1);
    step();
    drive(ADD_X5, 32'h0, 5'd0, 1'b0, 1'b0);
    check("run_done_ignored", 32'(outs()), 32'(NORM));

    // MDU handshake, done on cycle 5
    do_reset();
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    check("mdu_c0", 32'(outs()), 32'(MSTART));
    step();
    for (int c = 1; c < 5; c++) begin
      drive(ADD_X5, MUL, 5'd11, 1'b1, 1'b0);
      check($sformatf("mdu_c%0d", c), 32'(outs()), 32'(MWAIT));
      step();
    end
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b1);
    check("mdu_release", 32'(outs()), 32'(NORM));
    step();
    drive(ADD_X5, 32'h0, 5'd0, 1'b0, 1'b0);
    check("mdu_run", 32'(outs()), 32'(NORM));
    check("mdu_cnt", 32'(stall_count), 5);
    check("mdu_noerr", 32'(mdu_error), 0);

    // Timeout without done
    do_reset();
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    check("to_c0", 32'(outs()), 32'(MSTART));
    step();
    for (int c = 1; c < 8; c++) begin
      drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
      check($sformatf("to_c%0d", c), 32'(outs()), 32'(MWAIT));
      step();
    end
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    check("to_release", 32'(outs()), 32'(NORM));
    check("to_err_pre", 32'(mdu_error), 0);
    step();
    drive(ADD_X5, 32'h0, 5'd0, 1'b0, 1'b0);
    check("to_err", 32'(mdu_error), 1);
    check("to_cnt", 32'(stall_count), 8);
    step();
    step();
    check("to_err_sticky", 32'(mdu_error), 1);

    // Done coincident with timeout, then back-to-back M-op
    do_reset();
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    step();
    for (int c = 1; c < 8; c++) begin
      drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
      step();
    end
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b1);
    check("co_release", 32'(outs()), 32'(NORM));
    step();
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    check("co_noerr", 32'(mdu_error), 0);
    check("b2b_start", 32'(outs()), 32'(MSTART));
    step();

    // Reset during MDU_WAIT at cycle 3
    do_reset();
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    step();
    step();
    step();
    reset = 1'b1;
    drive(ADD_X5, MUL, 5'd11, 1'b0, 1'b0);
    check("rstw_forced", 32'(outs()), 32'(NORM));
    step();
    reset = 1'b0;
    drive(ADD_X5, 32'h0, 5'd0, 1'b0, 1'b0);
    check("rstw_run", 32'(outs()), 32'(NORM));
    check("rstw_err", 32'(mdu_error), 0);
    check("rstw_cnt", 32'(stall_count), 0);

    // Saturation with CNT_W=4
    do_reset();
    drive(ADD_X5, LW_X5, 5'd5, 1'b0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step();
      if (c == 13) check("sat_14", 32'(stall_count), 14);
    end
    check("sat_15", 32'(stall_count), 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
